// File: rtl/k6502_int_seq.sv
// k6502_int_seq: 6502 interrupt/reset entry sequencer (BRK-less RES/NMI/IRQ).
// Walks T0..T6: two dummy reads, three stack pushes (reads for RES),
// then the vector fetch. All outputs are registered and aligned with the state.
// Ports:
//   clk, rst_n        clock, async active-low reset (also requests RES)
//   res_req           level reset request
//   nmi_n             falling-edge NMI
//   irq_n, i_flag     level IRQ and its mask
//   sync, ready       opcode boundary marker, RDY (stalls read steps only)
//   busy, done        sequence active / one-clk completion pulse
//   t_step, kind      current step, accepted source (00/01 RES/10 NMI/11 IRQ)
//   rw                1 read, 0 write
//   remaining         datapath strobes
module k6502_int_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       res_req,
   input  logic       nmi_n,
   input  logic       irq_n,
   input  logic       i_flag,
   input  logic       sync,
   input  logic       ready,
   output logic       busy,
   output logic       done,
   output logic [2:0] t_step,
   output logic [1:0] kind,
   output logic       rw,
   output logic       pcl_adl,
   output logic       pch_adh,
   output logic       s_adl,
   output logic       adl_abl,
   output logic       adh_abh,
   output logic       z_adh7_1,
   output logic       z_adl0,
   output logic       z_adl1,
   output logic       z_adl2,
   output logic       pch_db,
   output logic       pcl_db,
   output logic       p_db,
   output logic       s_dec,
   output logic       dl_adh,
   output logic       adl_pcl,
   output logic       adh_pch,
   output logic       set_i
);

   localparam int unsigned STRB_W     = 17;
   localparam int unsigned B_PCL_ADL  = 0;
   localparam int unsigned B_PCH_ADH  = 1;
   localparam int unsigned B_S_ADL    = 2;
   localparam int unsigned B_ADL_ABL  = 3;
   localparam int unsigned B_ADH_ABH  = 4;
   localparam int unsigned B_Z_ADH7_1 = 5;
   localparam int unsigned B_Z_ADL0   = 6;
   localparam int unsigned B_Z_ADL1   = 7;
   localparam int unsigned B_Z_ADL2   = 8;
   localparam int unsigned B_PCH_DB   = 9;
   localparam int unsigned B_PCL_DB   = 10;
   localparam int unsigned B_P_DB     = 11;
   localparam int unsigned B_S_DEC    = 12;
   localparam int unsigned B_DL_ADH   = 13;
   localparam int unsigned B_ADL_PCL  = 14;
   localparam int unsigned B_ADH_PCH  = 15;
   localparam int unsigned B_SET_I    = 16;

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_RES  = 2'b01;
   localparam logic [1:0] K_NMI  = 2'b10;
   localparam logic [1:0] K_IRQ  = 2'b11;

   // T-step encodings equal the step number so t_step is a direct copy
   typedef enum logic [2:0] {
      S_T0   = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_IDLE = 3'd7
   } state_t;

   state_t              state, state_n;
   logic [1:0]          kind_n;
   logic                res_pend, res_pend_n;
   logic                nmi_prev, nmi_pend, nmi_pend_n;
   logic                nmi_edge, nmi_act, res_act, irq_act, stall;
   logic                busy_n, done_n, rw_n;
   logic [2:0]          t_step_n;
   logic [STRB_W-1:0]   strb, strb_n;

   // State, pending flags and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         kind     <= K_NONE;
         res_pend <= 1'b1;
         nmi_prev <= 1'b1;
         nmi_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         t_step   <= 3'd0;
         rw       <= 1'b1;
         strb     <= '0;
      end else begin
         state    <= state_n;
         kind     <= kind_n;
         res_pend <= res_pend_n;
         nmi_prev <= nmi_n;
         nmi_pend <= nmi_pend_n;
         busy     <= busy_n;
         done     <= done_n;
         t_step   <= t_step_n;
         rw       <= rw_n;
         strb     <= strb_n;
      end
   end

   // Next state, source arbitration and NMI hijack
   always_comb begin
      nmi_edge   = nmi_prev & ~nmi_n;
      nmi_act    = nmi_pend | nmi_edge;
      res_act    = res_pend | res_req;
      irq_act    = ~irq_n & ~i_flag;
      // rw is the registered read/write of the current step
      stall      = (state != S_IDLE) && rw && !ready;
      state_n    = state;
      kind_n     = kind;
      res_pend_n = res_pend | res_req;
      nmi_pend_n = nmi_act;
      done_n     = 1'b0;
      if (res_act) begin
         state_n    = S_T0;
         kind_n     = K_RES;
         res_pend_n = 1'b0;
      end else if (!stall) begin
         unique case (state)
            S_IDLE: begin
               if (sync && (nmi_act || irq_act)) begin
                  state_n = S_T0;
                  kind_n  = nmi_act ? K_NMI : K_IRQ;
               end
            end
            S_T5: begin
               state_n = S_T6;
               // NMI vector is being fetched; only a fresh edge stays pending
               if (kind == K_NMI) nmi_pend_n = nmi_edge;
            end
            S_T6: begin
               state_n = S_IDLE;
               kind_n  = K_NONE;
               done_n  = 1'b1;
            end
            default: begin
               state_n = state_t'(state + 3'd1);
               if (kind == K_IRQ && nmi_act) kind_n = K_NMI;
            end
         endcase
      end
   end

   // Output decode from the next state so outputs register in step
   always_comb begin
      busy_n   = (state_n != S_IDLE);
      t_step_n = busy_n ? 3'(state_n) : 3'd0;
      rw_n     = 1'b1;
      strb_n   = '0;
      unique case (state_n)
         S_T0, S_T1: begin
            strb_n[B_PCL_ADL] = 1'b1;
            strb_n[B_PCH_ADH] = 1'b1;
            strb_n[B_ADL_ABL] = 1'b1;
            strb_n[B_ADH_ABH] = 1'b1;
         end
         S_T2, S_T3, S_T4: begin
            // RES performs the stack cycles as reads
            rw_n               = (kind_n == K_RES);
            strb_n[B_S_ADL]    = 1'b1;
            strb_n[B_Z_ADH7_1] = 1'b1;
            strb_n[B_ADL_ABL]  = 1'b1;
            strb_n[B_ADH_ABH]  = 1'b1;
            strb_n[B_S_DEC]    = 1'b1;
            strb_n[B_PCH_DB]   = (state_n == S_T2);
            strb_n[B_PCL_DB]   = (state_n == S_T3);
            strb_n[B_P_DB]     = (state_n == S_T4);
         end
         S_T5, S_T6: begin
            strb_n[B_ADL_ABL] = 1'b1;
            strb_n[B_ADH_ABH] = 1'b1;
            strb_n[B_Z_ADL0]  = (state_n == S_T5);
            strb_n[B_Z_ADL1]  = (kind_n == K_RES);
            strb_n[B_Z_ADL2]  = (kind_n == K_NMI);
            strb_n[B_DL_ADH]  = (state_n == S_T6);
            strb_n[B_ADL_PCL] = (state_n == S_T6);
            strb_n[B_ADH_PCH] = (state_n == S_T6);
            strb_n[B_SET_I]   = (state_n == S_T6);
         end
         default: ;
      endcase
   end

   assign pcl_adl  = strb[B_PCL_ADL];
   assign pch_adh  = strb[B_PCH_ADH];
   assign s_adl    = strb[B_S_ADL];
   assign adl_abl  = strb[B_ADL_ABL];
   assign adh_abh  = strb[B_ADH_ABH];
   assign z_adh7_1 = strb[B_Z_ADH7_1];
   assign z_adl0   = strb[B_Z_ADL0];
   assign z_adl1   = strb[B_Z_ADL1];
   assign z_adl2   = strb[B_Z_ADL2];
   assign pch_db   = strb[B_PCH_DB];
   assign pcl_db   = strb[B_PCL_DB];
   assign p_db     = strb[B_P_DB];
   assign s_dec    = strb[B_S_DEC];
   assign dl_adh   = strb[B_DL_ADH];
   assign adl_pcl  = strb[B_ADL_PCL];
   assign adh_pch  = strb[B_ADH_PCH];
   assign set_i    = strb[B_SET_I];

endmodule

// File: tb/tb_k6502_int_seq.sv
// tb_k6502_int_seq: scoreboard bench for the interrupt sequencer.
// Expected per-step records are queued as each sequence is provoked and
// popped by a negedge monitor whenever the DUT is busy or pulses done.
module tb_k6502_int_seq;

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_RES  = 2'b01;
   localparam logic [1:0] K_NMI  = 2'b10;
   localparam logic [1:0] K_IRQ  = 2'b11;

   localparam int unsigned I_PCL_ADL  = 0;
   localparam int unsigned I_PCH_ADH  = 1;
   localparam int unsigned I_S_ADL    = 2;
   localparam int unsigned I_ADL_ABL  = 3;
   localparam int unsigned I_ADH_ABH  = 4;
   localparam int unsigned I_Z_ADH7_1 = 5;
   localparam int unsigned I_Z_ADL0   = 6;
   localparam int unsigned I_Z_ADL1   = 7;
   localparam int unsigned I_Z_ADL2   = 8;
   localparam int unsigned I_PCH_DB   = 9;
   localparam int unsigned I_PCL_DB   = 10;
   localparam int unsigned I_P_DB     = 11;
   localparam int unsigned I_S_DEC    = 12;
   localparam int unsigned I_DL_ADH   = 13;
   localparam int unsigned I_ADL_PCL  = 14;
   localparam int unsigned I_ADH_PCH  = 15;
   localparam int unsigned I_SET_I    = 16;

   logic clk, rst_n, res_req, nmi_n, irq_n, i_flag, sync, ready;
   logic busy, done, rw;
   logic [2:0] t_step;
   logic [1:0] kind;
   logic pcl_adl, pch_adh, s_adl, adl_abl, adh_abh, z_adh7_1, z_adl0, z_adl1, z_adl2;
   logic pch_db, pcl_db, p_db, s_dec, dl_adh, adl_pcl, adh_pch, set_i;

   logic [16:0] obs_strb;
   logic [15:0] obs_vec;

   typedef struct {
      logic [2:0]  step;
      logic [1:0]  kind;
      logic        kchk;
      logic        rw;
      logic [16:0] strb;
      logic        busy;
      logic        done;
      logic [15:0] vec;
      logic        vchk;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   k6502_int_seq dut (
      .clk(clk), .rst_n(rst_n), .res_req(res_req), .nmi_n(nmi_n), .irq_n(irq_n),
      .i_flag(i_flag), .sync(sync), .ready(ready),
      .busy(busy), .done(done), .t_step(t_step), .kind(kind), .rw(rw),
      .pcl_adl(pcl_adl), .pch_adh(pch_adh), .s_adl(s_adl), .adl_abl(adl_abl),
      .adh_abh(adh_abh), .z_adh7_1(z_adh7_1), .z_adl0(z_adl0), .z_adl1(z_adl1),
      .z_adl2(z_adl2), .pch_db(pch_db), .pcl_db(pcl_db), .p_db(p_db), .s_dec(s_dec),
      .dl_adh(dl_adh), .adl_pcl(adl_pcl), .adh_pch(adh_pch), .set_i(set_i)
   );

   assign obs_strb = {set_i, adh_pch, adl_pcl, dl_adh, s_dec, p_db, pcl_db, pch_db,
                      z_adl2, z_adl1, z_adl0, z_adh7_1, adh_abh, adl_abl, s_adl,
                      pch_adh, pcl_adl};
   // ADH floats to FF; ADL is FF with the zeroed bits cleared
   assign obs_vec  = {8'hFF, 5'b11111, ~z_adl2, ~z_adl1, ~z_adl0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [16:0] exp_strb(input int step, input logic [1:0] k);
      logic [16:0] s;
      s = '0;
      case (step)
         0, 1: begin
            s[I_PCL_ADL] = 1'b1; s[I_PCH_ADH] = 1'b1;
            s[I_ADL_ABL] = 1'b1; s[I_ADH_ABH] = 1'b1;
         end
         2, 3, 4: begin
            s[I_S_ADL] = 1'b1; s[I_Z_ADH7_1] = 1'b1; s[I_ADL_ABL] = 1'b1;
            s[I_ADH_ABH] = 1'b1; s[I_S_DEC] = 1'b1;
            if (step == 2) s[I_PCH_DB] = 1'b1;
            if (step == 3) s[I_PCL_DB] = 1'b1;
            if (step == 4) s[I_P_DB]   = 1'b1;
         end
         5, 6: begin
            s[I_ADL_ABL] = 1'b1; s[I_ADH_ABH] = 1'b1;
            if (step == 5) s[I_Z_ADL0] = 1'b1;
            if (k == K_RES) s[I_Z_ADL1] = 1'b1;
            if (k == K_NMI) s[I_Z_ADL2] = 1'b1;
            if (step == 6) begin
               s[I_DL_ADH] = 1'b1; s[I_ADL_PCL] = 1'b1;
               s[I_ADH_PCH] = 1'b1; s[I_SET_I] = 1'b1;
            end
         end
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic [15:0] exp_vec(input logic [1:0] k, input int step);
      logic [15:0] v;
      case (k)
         K_NMI:   v = 16'hFFFA;
         K_RES:   v = 16'hFFFC;
         default: v = 16'hFFFE;
      endcase
      return (step == 6) ? (v | 16'h0001) : v;
   endfunction

   // Queue steps 0..last; kind k0 before step sw, k1 from sw on (step sw-1 unchecked
   // when they differ); step stall_step repeated stall_n extra times
   task automatic push_seq(input logic [1:0] k0, input logic [1:0] k1, input int sw,
                           input int stall_step, input int stall_n, input int last,
                           input bit with_done);
      exp_t e;
      for (int st = 0; st <= last; st++) begin
         logic [1:0] k;
         k      = (st >= sw) ? k1 : k0;
         e.step = 3'(st);
         e.kind = k;
         e.kchk = !((k0 != k1) && (st == sw - 1));
         e.rw   = (st >= 2 && st <= 4) ? (k == K_RES) : 1'b1;
         e.strb = exp_strb(st, k);
         e.busy = 1'b1;
         e.done = 1'b0;
         e.vec  = exp_vec(k, st);
         e.vchk = (st >= 5);
         for (int r = 0; r < ((st == stall_step) ? 1 + stall_n : 1); r++) sbq.push_back(e);
      end
      if (with_done) begin
         e.step = 3'd0; e.kind = K_NONE; e.kchk = 1'b0; e.rw = 1'b1; e.strb = '0;
         e.busy = 1'b0; e.done = 1'b1; e.vec = 16'h0; e.vchk = 1'b0;
         sbq.push_back(e);
      end
   endtask

   // Monitor: compare every busy/done cycle against the scoreboard head
   always @(negedge clk) begin
      if (busy === 1'b1 || done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected", {30'd0, busy, done}, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("t_step", 32'(t_step), 32'(mon_e.step));
            chk("busy",   32'(busy),   32'(mon_e.busy));
            chk("done",   32'(done),   32'(mon_e.done));
            chk("rw",     32'(rw),     32'(mon_e.rw));
            chk("strobes", 32'(obs_strb), 32'(mon_e.strb));
            if (mon_e.kchk) chk("kind", 32'(kind), 32'(mon_e.kind));
            if (mon_e.vchk) chk("vector", 32'(obs_vec), 32'(mon_e.vec));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (busy == 1'b0 && done == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_idle_timeout", {30'd0, busy, done}, 32'd0);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      sbq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; res_req = 1'b0; nmi_n = 1'b1; irq_n = 1'b1;
      i_flag = 1'b1; sync = 1'b0; ready = 1'b1;
      tick(3);
      chk("rst_busy",   32'(busy),     32'd0);
      chk("rst_done",   32'(done),     32'd0);
      chk("rst_t_step", 32'(t_step),   32'd0);
      chk("rst_kind",   32'(kind),     32'd0);
      chk("rst_rw",     32'(rw),       32'd1);
      chk("rst_strb",   32'(obs_strb), 32'd0);

      // Reset release starts a RES sequence without sync
      push_seq(K_RES, K_RES, 7, -1, 0, 6, 1'b1);
      rst_n = 1'b1;
      wait_idle(20);

      // Unmasked IRQ
      tick(2);
      push_seq(K_IRQ, K_IRQ, 7, -1, 0, 6, 1'b1);
      irq_n = 1'b0; i_flag = 1'b0; sync = 1'b1;
      tick(1);
      sync = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
      wait_idle(20);

      // Masked IRQ never starts
      irq_n = 1'b0; i_flag = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sync = i[0];
         tick(1);
         chk("masked_irq_busy", 32'(busy), 32'd0);
      end
      irq_n = 1'b1; sync = 1'b0;

      // IRQ hijacked by NMI falling in T3
      tick(1);
      push_seq(K_IRQ, K_NMI, 5, -1, 0, 6, 1'b1);
      irq_n = 1'b0; i_flag = 1'b0; sync = 1'b1;
      tick(1);
      sync = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
      tick(3);
      nmi_n = 1'b0;
      tick(2);
      nmi_n = 1'b1;
      wait_idle(20);
      sync = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("no_second_nmi", 32'(busy), 32'd0);
      end
      sync = 1'b0;

      // NMI with RDY low in T3 (ignored) and 3 clks in T5 (held)
      push_seq(K_NMI, K_NMI, 7, 5, 3, 6, 1'b1);
      nmi_n = 1'b0; sync = 1'b1;
      tick(1);
      sync = 1'b0;
      tick(3);
      ready = 1'b0;
      tick(1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(3);
      ready = 1'b1; nmi_n = 1'b1;
      wait_idle(20);

      // RES during NMI T4; the NMI stays pending for the next sync
      tick(1);
      push_seq(K_NMI, K_NMI, 7, -1, 0, 4, 1'b0);
      push_seq(K_RES, K_RES, 7, -1, 0, 6, 1'b1);
      nmi_n = 1'b0; sync = 1'b1;
      tick(1);
      sync = 1'b0;
      tick(4);
      res_req = 1'b1;
      tick(1);
      res_req = 1'b0;
      wait_idle(20);
      push_seq(K_NMI, K_NMI, 7, -1, 0, 6, 1'b1);
      sync = 1'b1;
      tick(1);
      sync = 1'b0; nmi_n = 1'b1;
      wait_idle(20);

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/k6502_int_seq.md
K6502_INT_SEQ -- requirements
Module: k6502_int_seq

Interface
REQ-001 SHALL have parameter NONE; all timing is fixed.
REQ-002 clk  in  1  single core clock; one clk edge = one 6502 T-step.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 res_req  in  1  level; 1 requests the reset sequence.
REQ-005 nmi_n  in  1  active-low, falling-edge triggered.
REQ-006 irq_n  in  1  active-low, level.
REQ-007 i_flag  in  1  P.I; 1 masks IRQ.
REQ-008 sync  in  1  1 = current step is an opcode-fetch boundary.
REQ-009 ready  in  1  RDY; 0 stalls read steps.
REQ-010 busy, done  out  1 each  sequence active; one-clk pulse at completion.
REQ-011 t_step  out  3  current step, 0..6.
REQ-012 kind  out  2  accepted source: 00 none, 01 RES, 10 NMI, 11 IRQ.
REQ-013 rw  out  1  1 read, 0 write.
REQ-014 pcl_adl, pch_adh, s_adl, adl_abl, adh_abh, z_adh7_1, z_adl0, z_adl1, z_adl2, pch_db, pcl_db, p_db, s_dec, dl_adh, adl_pcl, adh_pch, set_i  out  1 each  datapath strobes.

Function
REQ-015 States: IDLE, T0..T6; busy=1 in T0..T6; t_step=0 in IDLE.
REQ-016 nmi_pend SHALL set on a sampled 1->0 of nmi_n (previous-sample register); it SHALL clear on leaving T5 with kind=NMI.
REQ-017 res_pend SHALL set while res_req=1.
REQ-018 irq_pend SHALL be (irq_n=0 and i_flag=0), sampled each clk; it SHALL NOT be latched.
REQ-019 Priority: RES > NMI > IRQ.
REQ-020 IDLE -> T0 SHALL occur on the clk with sync=1 and any pending source; kind SHALL be latched then.
REQ-021 res_pend SHALL force T0 from any state on the next clk, with kind=RES.
REQ-022 Steps T0..T6 SHALL advance one per clk; T6 -> IDLE with done=1 for one clk.
REQ-023 T0,T1: rw=1, pcl_adl, pch_adh, adl_abl, adh_abh; PC not incremented.
REQ-024 T2/T3/T4: s_adl, z_adh7_1, adl_abl, adh_abh, s_dec; data strobe pch_db / pcl_db / p_db respectively; rw=0, except rw=1 for kind=RES.
REQ-025 T5: adl_abl, adh_abh, z_adl0, plus vector bits (RES z_adl1; NMI z_adl2; IRQ none); rw=1; ADH floats to FF.
REQ-026 T6: same vector bits without z_adl0 (odd address); rw=1, dl_adh, adl_pcl, adh_pch, set_i.
REQ-027 Vectors SHALL be: NMI FFFA/B, RES FFFC/D, IRQ FFFE/F.
REQ-028 Hijack: if kind=IRQ and nmi_pend is set at any clk before entering T5, kind SHALL switch to NMI.
REQ-029 ready=0 during a read step (rw=1) SHALL hold the state and all outputs; write steps SHALL ignore ready.
REQ-030 IDLE SHALL drive all strobes to 0 and rw=1.
REQ-031 An NMI edge during a sequence SHALL remain pending and start a new sequence at the next sync.

Reset
REQ-032 rst_n=0 SHALL force IDLE, busy=0, done=0, t_step=0, kind=00, all strobes 0, rw=1, nmi_pend=0, nmi_n history=1.
REQ-033 res_pend SHALL be set by rst_n=0, so a RES sequence starts on the first clk after release, regardless of sync.

Verification
REQ-034 Release rst_n, res_req=0 -> T0..T6 in 7 clks with rw=1 throughout, T5 address FFFC, T6 FFFD, done on clk 8.
REQ-035 irq_n=0, i_flag=0, sync=1 -> kind=11; rw=0 in T2-T4; z_adh7_1 in T2-T4; vector FFFE/FFFF.
REQ-036 irq_n=0, i_flag=1, sync pulsing -> busy stays 0.
REQ-037 IRQ sequence plus nmi_n falling in T3 -> kind=10 in T5, vector FFFA; nmi_pend cleared after T5; no second NMI sequence.
REQ-038 ready=0 for 3 clks in T5 -> t_step=5 held 3 clks; ready=0 during T3 -> no stall.
REQ-039 res_req=1 during NMI T4 -> next clk T0 with kind=01; NMI remains pending and is serviced at the following sync.
